// File: rtl/video_pixel_fifo_if.sv
// Handshake bundle between the frame-memory fetch side, the VGA pop side
// and the pixel FIFO. The master is the environment; the slave is the FIFO.
interface video_pixel_fifo_if #(
  parameter int PIX_W = 8,
  parameter int BSIZE = 4,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                   flush;
  logic [BSIZE*PIX_W-1:0] data;
  logic                   load;
  logic                   load_ready;
  logic                   en;
  logic [PIX_W-1:0]       video;
  logic                   video_valid;
  logic [LW-1:0]          level;
  logic                   watermark_on;
  logic                   empty;
  logic                   full;
  logic                   underrun;

  modport master (
    output flush, data, load, en,
    input  load_ready, video, video_valid, level,
           watermark_on, empty, full, underrun
  );

  modport slave (
    input  flush, data, load, en,
    output load_ready, video, video_valid, level,
           watermark_on, empty, full, underrun
  );
endinterface

// File: rtl/video_pixel_fifo.sv
// Pixel FIFO: wide BSIZE-pixel writes from frame fetch, single-pixel
// registered pops to the VGA output, with level/watermark and sticky underrun.
module video_pixel_fifo #(
  parameter int PIX_W     = 8,
  parameter int BSIZE     = 4,
  parameter int DEPTH     = 16,
  parameter int WATERMARK = 8
) (
  input logic               clk25MHz,
  input logic               rst,
  video_pixel_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [PIX_W-1:0] r_video;
  logic             r_video_valid;
  logic             r_underrun;

  logic [PIX_W-1:0] w_pix [BSIZE];
  logic             w_load_ready;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  for (genvar gi = 0; gi < BSIZE; gi++) begin : g_unpack
    assign w_pix[gi] = bus.data[gi*PIX_W +: PIX_W];
  end

  // Status is derived only from the registered level, never from this cycle's requests.
  assign w_load_ready = (r_level <= LW'(DEPTH - BSIZE));
  assign w_empty      = (r_level == '0);
  assign w_wr         = bus.load && w_load_ready && !bus.flush && !rst;
  assign w_rd         = bus.en && !w_empty && !bus.flush;

  assign bus.load_ready   = w_load_ready;
  assign bus.empty        = w_empty;
  assign bus.full         = (r_level == LW'(DEPTH));
  assign bus.watermark_on = (r_level <= LW'(WATERMARK));
  assign bus.level        = r_level;
  assign bus.video        = r_video;
  assign bus.video_valid  = r_video_valid;
  assign bus.underrun     = r_underrun;

  // wptr stays BSIZE-aligned, so the word never wraps mid-write.
  always_ff @(posedge clk25MHz) begin
    if (w_wr) begin
      for (int i = 0; i < BSIZE; i++) begin
        r_mem[r_wptr + AW'(i)] <= w_pix[i];
      end
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_level       <= '0;
      r_video       <= '0;
      r_video_valid <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (bus.flush) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_level       <= '0;
      r_video_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(BSIZE);
      end
      if (w_rd) begin
        r_video       <= r_mem[r_rptr];
        r_video_valid <= 1'b1;
        r_rptr        <= r_rptr + AW'(1);
      end else begin
        r_video_valid <= 1'b0;
      end
      if (bus.en && w_empty) begin
        r_underrun <= 1'b1;
      end
      r_level <= r_level + (w_wr ? LW'(BSIZE) : LW'(0)) - (w_rd ? LW'(1) : LW'(0));
    end
  end
endmodule
